// File: rtl/branch_pkg.sv
// Shared fetch/branch-prediction types: default widths, fetch FSM
// states, 2-bit counter encodings and the registered BTB write bundle.
package branch_pkg;

  localparam int ADDR_WIDTH      = 64;
  localparam int INDEX_WIDTH     = 2;
  localparam int BIA_WIDTH       = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int BHT_INDEX_WIDTH = 4;
  localparam int BTB_WAYS        = 4;
  localparam int WAY_WIDTH       = $clog2(BTB_WAYS);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } fetch_state_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic                   we;
    logic [BIA_WIDTH-1:0]   bia;
    logic [INDEX_WIDTH-1:0] index;
    logic [WAY_WIDTH-1:0]   way;
    logic [ADDR_WIDTH-1:0]  target;
  } btb_wr_t;

  function automatic logic [1:0] sat_update(
    input logic [1:0] cnt,
    input logic       taken
  );
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != ST) nxt = cnt + 2'd1;
    if (!taken && cnt != SNT) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Bimodal history table: 2-bit saturating counters, async read of the
// direction bit, one training write per cycle.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] cnt_d [ENTRIES];

  // Read sees the registered array, so a same-cycle update is not bypassed.
  assign rd_taken_o = cnt_q[rd_idx_i][1];

  always_comb begin
    cnt_d = cnt_q;
    if (upd_en_i) begin
      cnt_d[upd_idx_i] = sat_update(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '{default: WNT};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch next-PC generator: holds the fetch PC, predicts with BTB + BHT,
// redirects on execute mispredicts and registers the BTB write port.
module fetch_pc_gen #(
  parameter int ADDR_WIDTH      = branch_pkg::ADDR_WIDTH,
  parameter int N               = branch_pkg::BTB_WAYS,
  parameter int INDEX_WIDTH     = branch_pkg::INDEX_WIDTH,
  parameter int BIA_WIDTH       = ADDR_WIDTH - INDEX_WIDTH - 2,
  parameter int BHT_INDEX_WIDTH = branch_pkg::BHT_INDEX_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic                   o_pred_taken,
  output logic [ADDR_WIDTH-1:0]  o_pred_target,
  output logic [$clog2(N)-1:0]   o_btb_way,
  input  logic                   i_btb_hit,
  input  logic [ADDR_WIDTH-1:0]  i_btb_target,
  input  logic [$clog2(N)-1:0]   i_btb_way,
  input  logic                   i_res_valid,
  input  logic                   i_res_is_branch,
  input  logic [ADDR_WIDTH-1:0]  i_res_pc,
  input  logic                   i_res_taken,
  input  logic [ADDR_WIDTH-1:0]  i_res_target,
  input  logic [$clog2(N)-1:0]   i_res_way,
  input  logic                   i_res_mispredict,
  output logic                   o_btb_we,
  output logic [BIA_WIDTH-1:0]   o_btb_bia,
  output logic [INDEX_WIDTH-1:0] o_btb_index,
  output logic [$clog2(N)-1:0]   o_btb_way_write,
  output logic [ADDR_WIDTH-1:0]  o_btb_target
);

  import branch_pkg::*;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] seq_pc, res_seq_pc;
  btb_wr_t               btb_q, btb_d;
  logic                  bht_taken;
  logic                  redirect, train;

  assign seq_pc     = pc_q + ADDR_WIDTH'(4);
  assign res_seq_pc = i_res_pc + ADDR_WIDTH'(4);
  assign redirect   = i_res_valid & i_res_mispredict;
  assign train      = i_res_valid & i_res_is_branch;

  assign o_valid       = (state_q == FETCH);
  assign o_pc          = pc_q;
  assign o_pred_taken  = i_btb_hit & bht_taken;
  assign o_pred_target = o_pred_taken ? i_btb_target : seq_pc;
  assign o_btb_way     = i_btb_way;

  bht_2bit #(
    .IDX_W(BHT_INDEX_WIDTH)
  ) u_bht (
    .clk_i      (i_clk),
    .rst_i      (i_arst),
    .rd_idx_i   (pc_q[BHT_INDEX_WIDTH+1:2]),
    .rd_taken_o (bht_taken),
    .upd_en_i   (train),
    .upd_idx_i  (i_res_pc[BHT_INDEX_WIDTH+1:2]),
    .upd_taken_i(i_res_taken)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (i_ready) pc_d = o_pred_target;
      FLUSH:   state_d = FETCH;
      default: state_d = IDLE;
    endcase
    // A mispredict beats stall, IDLE and FLUSH alike.
    if (redirect) begin
      state_d = FLUSH;
      pc_d    = i_res_taken ? i_res_target : res_seq_pc;
    end
  end

  always_comb begin
    btb_d    = btb_q;
    btb_d.we = train & i_res_taken;
    if (btb_d.we) begin
      btb_d.bia    = i_res_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
      btb_d.index  = i_res_pc[INDEX_WIDTH+1:2];
      btb_d.way    = i_res_way;
      btb_d.target = i_res_target;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      btb_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      btb_q   <= btb_d;
    end
  end

  assign o_btb_we        = btb_q.we;
  assign o_btb_bia       = btb_q.bia;
  assign o_btb_index     = btb_q.index;
  assign o_btb_way_write = btb_q.way;
  assign o_btb_target    = btb_q.target;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: cycle model feeds a scoreboard queue, plus
// directed checks on the documented fetch/redirect scenarios.
module tb_fetch_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst, ready;
  logic        btb_hit;
  logic [63:0] btb_target;
  logic [1:0]  btb_way;
  logic        res_valid, res_br, res_taken, res_mis;
  logic [63:0] res_pc, res_target;
  logic [1:0]  res_way;

  logic        valid, pred_taken, btb_we;
  logic [63:0] pc, pred_target, btb_tgt;
  logic [1:0]  way_o, btb_index, btb_way_w;
  logic [59:0] btb_bia;

  fetch_pc_gen #(
    .RESET_PC(64'h1000)
  ) dut (
    .i_clk           (clk),
    .i_arst          (arst),
    .i_ready         (ready),
    .o_valid         (valid),
    .o_pc            (pc),
    .o_pred_taken    (pred_taken),
    .o_pred_target   (pred_target),
    .o_btb_way       (way_o),
    .i_btb_hit       (btb_hit),
    .i_btb_target    (btb_target),
    .i_btb_way       (btb_way),
    .i_res_valid     (res_valid),
    .i_res_is_branch (res_br),
    .i_res_pc        (res_pc),
    .i_res_taken     (res_taken),
    .i_res_target    (res_target),
    .i_res_way       (res_way),
    .i_res_mispredict(res_mis),
    .o_btb_we        (btb_we),
    .o_btb_bia       (btb_bia),
    .o_btb_index     (btb_index),
    .o_btb_way_write (btb_way_w),
    .o_btb_target    (btb_tgt)
  );

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic        pt;
    logic [63:0] ptg;
    logic [1:0]  way;
    logic        we;
    logic [59:0] bia;
    logic [1:0]  idx;
    logic [1:0]  wway;
    logic [63:0] tgt;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_pc;
  int          m_st;
  logic [1:0]  m_bht [16];
  logic        m_we;
  logic [59:0] m_bia;
  logic [1:0]  m_idx, m_wway;
  logic [63:0] m_tgt;

  logic        obs_v, obs_pt, obs_we;
  logic [63:0] obs_pc, obs_ptg, obs_tgt;
  logic [59:0] obs_bia;
  logic [1:0]  obs_idx, obs_way, obs_wway;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 64'h1000;
    m_st  = 0;
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_we   = 1'b0;
    m_bia  = '0;
    m_idx  = '0;
    m_wway = '0;
    m_tgt  = '0;
  endtask

  task automatic res_set(input logic [63:0] p, input logic tk,
                         input logic [63:0] t, input logic [1:0] w,
                         input logic br, input logic mis);
    res_valid  = 1'b1;
    res_pc     = p;
    res_taken  = tk;
    res_target = t;
    res_way    = w;
    res_br     = br;
    res_mis    = mis;
  endtask

  task automatic res_clr();
    res_valid = 1'b0;
    res_br    = 1'b0;
    res_mis   = 1'b0;
    res_taken = 1'b0;
  endtask

  task automatic cycle();
    exp_t e, g;
    logic [1:0] c;
    e.v    = (m_st == 1);
    e.pc   = m_pc;
    e.pt   = btb_hit & m_bht[m_pc[5:2]][1];
    e.ptg  = e.pt ? btb_target : m_pc + 64'd4;
    e.way  = btb_way;
    e.we   = m_we;
    e.bia  = m_bia;
    e.idx  = m_idx;
    e.wway = m_wway;
    e.tgt  = m_tgt;
    sb.push_back(e);
    if (arst) begin
      model_reset();
    end else begin
      if (res_valid && res_br) begin
        c = m_bht[res_pc[5:2]];
        if (res_taken) m_bht[res_pc[5:2]] = (c == 2'b11) ? c : c + 2'd1;
        else           m_bht[res_pc[5:2]] = (c == 2'b00) ? c : c - 2'd1;
      end
      m_we = res_valid && res_br && res_taken;
      if (m_we) begin
        m_bia  = res_pc[63:4];
        m_idx  = res_pc[3:2];
        m_wway = res_way;
        m_tgt  = res_target;
      end
      if (res_valid && res_mis) begin
        m_pc = res_taken ? res_target : res_pc + 64'd4;
        m_st = 2;
      end else if (m_st != 1) begin
        m_st = 1;
      end else if (ready) begin
        m_pc = e.ptg;
      end
    end
    @(negedge clk);
    g = sb.pop_front();
    obs_v = valid;  obs_pc = pc;  obs_pt = pred_taken;
    obs_ptg = pred_target;  obs_way = way_o;  obs_we = btb_we;
    obs_bia = btb_bia;  obs_idx = btb_index;  obs_wway = btb_way_w;
    obs_tgt = btb_tgt;
    check("valid", obs_v, g.v);
    check("pc", obs_pc, g.pc);
    check("pred_taken", obs_pt, g.pt);
    check("pred_target", obs_ptg, g.ptg);
    check("btb_way", obs_way, g.way);
    check("btb_we", obs_we, g.we);
    check("btb_bia", obs_bia, g.bia);
    check("btb_index", obs_idx, g.idx);
    check("btb_way_write", obs_wway, g.wway);
    check("btb_target", obs_tgt, g.tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [63:0] t);
    res_set(64'h0, 1'b1, t, 2'd0, 1'b0, 1'b1);
    cycle();
    res_clr();
    cycle();
  endtask

  initial begin
    arst = 1'b1;  ready = 1'b1;
    btb_hit = 1'b0;  btb_target = '0;  btb_way = '0;
    res_pc = '0;  res_target = '0;  res_way = '0;
    res_clr();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    arst = 1'b0;

    cycle();
    check("tp1_idle_valid", obs_v, 1'b0);
    check("tp1_idle_pc", obs_pc, 64'h1000);
    cycle();  check("tp1_pc0", obs_pc, 64'h1000);
    cycle();  check("tp1_pc1", obs_pc, 64'h1004);
    cycle();  check("tp1_pc2", obs_pc, 64'h1008);
    check("tp1_we", obs_we, 1'b0);

    res_set(64'h1008, 1'b1, 64'h2000, 2'd2, 1'b1, 1'b1);
    cycle();
    res_clr();
    cycle();
    check("tp2_bubble", obs_v, 1'b0);
    check("tp2_pc", obs_pc, 64'h2000);
    check("tp2_we", obs_we, 1'b1);
    check("tp2_bia", obs_bia, 64'h100);
    check("tp2_index", obs_idx, 2'd2);
    check("tp2_way", obs_wway, 2'd2);
    check("tp2_target", obs_tgt, 64'h2000);
    cycle();
    check("tp2_fetch", obs_v, 1'b1);
    check("tp2_we_drop", obs_we, 1'b0);

    res_set(64'h1008, 1'b1, 64'h2000, 2'd2, 1'b1, 1'b0);
    cycle();
    res_clr();
    redirect_to(64'h1008);
    btb_hit = 1'b1;  btb_target = 64'h2000;  btb_way = 2'd1;
    cycle();
    check("tp3_pred_taken", obs_pt, 1'b1);
    check("tp3_pred_target", obs_ptg, 64'h2000);
    btb_hit = 1'b0;

    // Walk to SNT, then one more not-taken must stay saturated.
    for (int i = 0; i < 4; i++) begin
      res_set(64'h1008, 1'b0, 64'h0, 2'd0, 1'b1, 1'b0);
      cycle();
    end
    res_set(64'h1008, 1'b1, 64'h2000, 2'd0, 1'b1, 1'b0);
    cycle();
    res_clr();
    redirect_to(64'h1008);
    btb_hit = 1'b1;
    cycle();
    check("tp3_nt_pred", obs_pt, 1'b0);
    check("tp3_nt_target", obs_ptg, 64'h100C);
    btb_hit = 1'b0;

    for (int i = 0; i < 4; i++) begin
      res_set(64'h1010, (i < 3), 64'h3000, 2'd0, 1'b1, 1'b0);
      cycle();
    end
    res_clr();
    redirect_to(64'h1010);
    btb_hit = 1'b1;  btb_target = 64'h3000;
    cycle();
    check("sat_hi_pred", obs_pt, 1'b1);
    btb_hit = 1'b0;

    redirect_to(64'h1000);
    cycle();
    ready = 1'b0;  btb_hit = 1'b1;  btb_target = 64'h3000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_pc", obs_pc, 64'h1004);
      check("stall_valid", obs_v, 1'b1);
      check("stall_ptg", obs_ptg, 64'h1008);
    end
    ready = 1'b1;
    cycle();
    cycle();
    check("stall_release", obs_pc, 64'h1008);
    btb_hit = 1'b0;

    ready = 1'b0;
    res_set(64'h0, 1'b1, 64'h4000, 2'd0, 1'b0, 1'b1);
    cycle();
    res_set(64'h0, 1'b1, 64'h5000, 2'd0, 1'b0, 1'b1);
    cycle();
    check("mis_stall_pc", obs_pc, 64'h4000);
    check("mis_stall_v", obs_v, 1'b0);
    res_clr();
    cycle();
    check("mis_flush_pc", obs_pc, 64'h5000);
    check("mis_flush_v", obs_v, 1'b0);
    cycle();
    check("mis_refetch", obs_v, 1'b1);
    ready = 1'b1;
    cycle();

    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    check("wrap_ptg", obs_ptg, 64'h0);
    cycle();
    check("wrap_pc", obs_pc, 64'h0);

    res_set(64'h1008, 1'b1, 64'h2000, 2'd3, 1'b1, 1'b0);
    cycle();
    res_clr();
    arst = 1'b1;
    cycle();
    check("rst_we_pending", obs_we, 1'b1);
    arst = 1'b0;
    cycle();
    check("rst_we", obs_we, 1'b0);
    check("rst_pc", obs_pc, 64'h1000);
    check("rst_valid", obs_v, 1'b0);
    check("rst_bia", obs_bia, 64'h0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Fetch-stage next-PC generator that sits directly upstream of the branch target buffer (BTB).
- Holds the architectural fetch PC and drives it to the BTB as the lookup address.
- Combines the BTB hit/target with an internal 2-bit bimodal history table (BHT) to choose the next PC.
- Hands PC plus prediction metadata to decode over a valid/ready handshake.
- Accepts branch resolution from execute to redirect, train the BHT, and produce the registered BTB write port.

Parameters:
ADDR_WIDTH, 64, PC/target width
N, 4, BTB associativity (way field = $clog2(N))
INDEX_WIDTH, 2, BTB set-index width
BIA_WIDTH, 60, BTB tag width (ADDR_WIDTH-INDEX_WIDTH-2)
BHT_INDEX_WIDTH, 4, log2 of BHT entries; indexed by pc[BHT_INDEX_WIDTH+1:2]
RESET_PC, 64'h0, fetch PC after reset

Ports:
i_clk  in  1  clock
i_arst  in  1  reset, synchronous, active-high
i_ready  in  1  decode accepts current fetch packet
o_valid  out  1  fetch packet valid
o_pc  out  ADDR_WIDTH  PC of current packet; also drives BTB i_pc
o_pred_taken  out  1  predicted taken
o_pred_target  out  ADDR_WIDTH  predicted next PC
o_btb_way  out  $clog2(N)  BTB way (hit way or PLRU victim), carried to execute
i_btb_hit  in  1  BTB hit for o_pc
i_btb_target  in  ADDR_WIDTH  BTB target for o_pc
i_btb_way  in  $clog2(N)  BTB way for o_pc
i_res_valid  in  1  resolution valid
i_res_is_branch  in  1  resolved instr is a branch/jump
i_res_pc  in  ADDR_WIDTH  resolved instr PC
i_res_taken  in  1  actual direction
i_res_target  in  ADDR_WIDTH  actual taken target
i_res_way  in  $clog2(N)  way carried from o_btb_way
i_res_mispredict  in  1  execute detected a wrong next PC
o_btb_we  out  1  BTB write enable (to i_branch_taken)
o_btb_bia  out  BIA_WIDTH  i_res_pc[ADDR_WIDTH-1:INDEX_WIDTH+2]
o_btb_index  out  INDEX_WIDTH  i_res_pc[INDEX_WIDTH+1:2]
o_btb_way_write  out  $clog2(N)  BTB write way
o_btb_target  out  ADDR_WIDTH  BTB write target

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, o_valid=0, o_btb_we=0, all BTB write fields 0, every BHT entry=2'b01 (weakly not-taken).
- State machine:
  - IDLE: o_valid=0. Unconditionally goes to FETCH next cycle.
  - FETCH: o_valid=1.
  - FLUSH: o_valid=0 for exactly one cycle, then FETCH.
- Prediction is combinational in the same cycle as o_pc:
  - o_pred_taken = i_btb_hit & bht[o_pc idx][1].
  - o_pred_target = o_pred_taken ? i_btb_target : o_pc+4, modulo 2^ADDR_WIDTH (wraps, no carry out).
  - o_btb_way = i_btb_way.
- PC update priority, per clock edge:
  - i_res_valid & i_res_mispredict: pc <= i_res_taken ? i_res_target : i_res_pc+4; state <= FLUSH. Overrides stall, IDLE and FLUSH.
  - FETCH & o_valid & i_ready: pc <= o_pred_target.
  - FETCH & !i_ready: pc and all outputs hold stable.
  - IDLE or FLUSH: pc holds.
- BHT training on i_res_valid & i_res_is_branch:
  - entry[i_res_pc idx] saturating +1 if taken, -1 if not taken.
  - Saturates at 2'b11 and 2'b00.
  - Same-cycle read/write to one entry: the read returns the old value; the new value is visible next cycle.
- BTB write is registered with 1-cycle latency:
  - Cycle after i_res_valid & i_res_is_branch & i_res_taken: o_btb_we=1 with bia/index/way/target captured from the i_res_* fields.
  - o_btb_we is 0 otherwise; fields hold their last value.
  - Not-taken branches never write the BTB.
- Non-branch resolution (i_res_is_branch=0): no BHT or BTB effect; a mispredict still redirects.
- Reset asserted mid-operation: all state returns to reset values at that edge, and any pending o_btb_we is dropped.

Decomposition:
- Shared package branch_pkg:
  - default widths (ADDR_WIDTH, INDEX_WIDTH, BIA_WIDTH, BHT_INDEX_WIDTH)
  - fetch state enum {IDLE, FETCH, FLUSH}
  - 2-bit counter localparams (SNT=00, WNT=01, WT=10, ST=11)
  - BTB write-request struct {we, bia, index, way, target}
- Sub-module bht_2bit: counter array with reset, combinational read port and saturating update port.
- The FSM, PC register and BTB write register stay in fetch_pc_gen.

Test Plan:
- Reset, RESET_PC=0x1000, i_ready=1, no BTB hits -> o_valid=0 in cycle 1; o_pc=0x1000, 0x1004, 0x1008 on successive cycles; o_btb_we=0 throughout.
- Resolve pc=0x1008 taken to 0x2000, way=2, mispredict -> next o_pc=0x2000 with one o_valid=0 bubble; one cycle later o_btb_we=1, bia=0x1008>>4, index=2, way=2, target=0x2000.
- Two taken resolves on 0x1008 (WNT->WT->ST) with BTB hit target 0x2000 -> fetch at 0x1008 gives o_pred_taken=1, o_pred_target=0x2000; three not-taken resolves give o_pred_taken=0.
- i_ready=0 for 3 cycles at o_pc=0x1004 -> o_pc, o_valid and o_pred_* stable; advances to 0x1008 on the first i_ready=1 edge.
- Mispredict during i_ready=0, and mispredict in FLUSH -> redirect target wins in both cases; exactly one bubble after the last mispredict.
- pc=0xFFFF_FFFF_FFFF_FFFC, no hit -> next o_pc=0x0; reset asserted while o_btb_we pending -> o_btb_we=0 and o_pc=RESET_PC after the reset edge.
